// File: rtl/riscv_multicycle_if.sv
// Memory-side bundle of the multi-cycle RV32 core: instruction and data
// req/ack channels plus the retire and halt status strobes.
interface riscv_multicycle_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_i;
    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_o;
    logic        data_ack_i;
    logic [31:0] data_i;
    logic        retire_o;
    logic        halt_o;

    modport master (
        output inst_req_o, inst_addr_o, data_req_o, data_we_o,
               data_addr_o, data_o, retire_o, halt_o,
        input  inst_ack_i, inst_i, data_ack_i, data_i
    );

    modport slave (
        input  inst_req_o, inst_addr_o, data_req_o, data_we_o,
               data_addr_o, data_o, retire_o, halt_o,
        output inst_ack_i, inst_i, data_ack_i, data_i
    );
endinterface

// File: rtl/riscv_multicycle.sv
// Multi-cycle RV32 integer core (FETCH/DECODE/EXEC/MEM/WB/HALT) with req/ack memories.
// Define RV_ILLEGAL_TRAP_EN to halt on illegal instructions; otherwise they retire as NOPs.
module riscv_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic               clk,
    input  logic               rst,
    riscv_multicycle_if.master bus
);
    if (XLEN != 32) begin : g_xlen_check
        $error("riscv_multicycle supports only XLEN = 32");
    end

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_XOR, OP_SRL, OP_OR, OP_AND,
        OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BLT, OP_BGE, OP_JAL, OP_NOP
    } op_t;

    state_t      state, next_state;
    op_t         op, dec_op;
    logic        dec_illegal;
    logic [31:0] pc, ir, imm, dec_imm, rs1_val, rs2_val;
    logic [31:0] alu, result, next_pc, exec_next_pc, load_data;
    logic        taken, writes_rd;
    logic [31:0] regs [32];

    logic        inst_req, data_req, data_we, retire, halt;
    logic [31:0] data_addr, data_wdata;
    logic        nxt_inst_req, nxt_data_req, nxt_data_we, nxt_retire, nxt_halt;
    logic [31:0] nxt_data_addr, nxt_data_wdata;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic       inst_fire, data_fire;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // An ack only counts while our own request is up.
    assign inst_fire = inst_req && bus.inst_ack_i;
    assign data_fire = data_req && bus.data_ack_i;

    assign bus.inst_req_o  = inst_req;
    assign bus.inst_addr_o = pc;
    assign bus.data_req_o  = data_req;
    assign bus.data_we_o   = data_we;
    assign bus.data_addr_o = data_addr;
    assign bus.data_o      = data_wdata;
    assign bus.retire_o    = retire;
    assign bus.halt_o      = halt;

    always_comb begin
        dec_op      = OP_NOP;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                case ({funct7, funct3})
                    10'b0000000_000: dec_op = OP_ADD;
                    10'b0100000_000: dec_op = OP_SUB;
                    10'b0000000_001: dec_op = OP_SLL;
                    10'b0000000_100: dec_op = OP_XOR;
                    10'b0000000_101: dec_op = OP_SRL;
                    10'b0000000_110: dec_op = OP_OR;
                    10'b0000000_111: dec_op = OP_AND;
                    default:         dec_illegal = 1'b1;
                endcase
            end
            7'b0010011: if (funct3 == 3'b000) dec_op = OP_ADDI; else dec_illegal = 1'b1;
            7'b0000011: if (funct3 == 3'b010) dec_op = OP_LW;   else dec_illegal = 1'b1;
            7'b0100011: if (funct3 == 3'b010) dec_op = OP_SW;   else dec_illegal = 1'b1;
            7'b1100011: begin
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b1101111: dec_op = OP_JAL;
            default:    dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (opcode)
            7'b0100011: dec_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: dec_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b1101111: dec_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:    dec_imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    always_comb begin
        alu = 32'd0;
        case (op)
            OP_ADD:                alu = rs1_val + rs2_val;
            OP_SUB:                alu = rs1_val - rs2_val;
            OP_SLL:                alu = rs1_val << rs2_val[4:0];
            OP_XOR:                alu = rs1_val ^ rs2_val;
            OP_SRL:                alu = rs1_val >> rs2_val[4:0];
            OP_OR:                 alu = rs1_val | rs2_val;
            OP_AND:                alu = rs1_val & rs2_val;
            OP_ADDI, OP_LW, OP_SW: alu = rs1_val + imm;
            OP_JAL:                alu = pc + 32'd4;
            default:               alu = 32'd0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = (rs1_val == rs2_val);
            OP_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            OP_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            OP_JAL:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        exec_next_pc = taken ? (pc + imm) : (pc + 32'd4);
    end

    always_comb begin
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_XOR, OP_SRL, OP_OR, OP_AND,
            OP_ADDI, OP_LW, OP_JAL: writes_rd = 1'b1;
            default:                writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (inst_fire) next_state = DECODE;
            DECODE: begin
`ifdef RV_ILLEGAL_TRAP_EN
                next_state = dec_illegal ? HALT : EXEC;
`else
                next_state = EXEC;
`endif
            end
            EXEC:   next_state = (op == OP_LW || op == OP_SW) ? MEM : WB;
            MEM:    if (data_fire) next_state = WB;
            WB:     next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Outputs are registered: compute their values for the state being entered.
    always_comb begin
        nxt_inst_req   = (next_state == FETCH);
        nxt_data_req   = (next_state == MEM);
        nxt_retire     = (next_state == WB);
        nxt_halt       = (next_state == HALT);
        nxt_data_we    = data_we;
        nxt_data_addr  = data_addr;
        nxt_data_wdata = data_wdata;
        if (state == EXEC && next_state == MEM) begin
            nxt_data_we    = (op == OP_SW);
            nxt_data_addr  = alu;
            nxt_data_wdata = rs2_val;
        end else if (state == MEM && next_state == WB) begin
            nxt_data_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            inst_req   <= 1'b0;
            data_req   <= 1'b0;
            data_we    <= 1'b0;
            retire     <= 1'b0;
            halt       <= 1'b0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
        end else begin
            state      <= next_state;
            inst_req   <= nxt_inst_req;
            data_req   <= nxt_data_req;
            data_we    <= nxt_data_we;
            retire     <= nxt_retire;
            halt       <= nxt_halt;
            data_addr  <= nxt_data_addr;
            data_wdata <= nxt_data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= 32'd0;
            op        <= OP_NOP;
            imm       <= 32'd0;
            rs1_val   <= 32'd0;
            rs2_val   <= 32'd0;
            result    <= 32'd0;
            next_pc   <= RESET_PC;
            load_data <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            case (state)
                FETCH: if (inst_fire) ir <= bus.inst_i;
                DECODE: begin
                    op      <= dec_illegal ? OP_NOP : dec_op;
                    imm     <= dec_imm;
                    rs1_val <= (rs1 == 5'd0) ? 32'd0 : regs[rs1];
                    rs2_val <= (rs2 == 5'd0) ? 32'd0 : regs[rs2];
                end
                EXEC: begin
                    result  <= alu;
                    next_pc <= exec_next_pc;
                end
                MEM: if (data_fire && !data_we) load_data <= bus.data_i;
                WB: begin
                    pc <= next_pc;
                    if (writes_rd && rd != 5'd0)
                        regs[rd] <= (op == OP_LW) ? load_data : result;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: scripted memory responses, retire timing and store checks.
module tb_riscv_multicycle;
    logic clk = 1'b0;
    logic rst;

    riscv_multicycle_if bus ();

    riscv_multicycle #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned retire_cyc[$];
    int data_txn = 0;

    // Samples at the rising edge, before the core's registered outputs update.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.retire_o === 1'b1) retire_cyc.push_back(cyc);
        if (bus.data_req_o === 1'b1 && bus.data_ack_i === 1'b1) data_txn++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] rdata);
        rst             = r;
        bus.data_ack_i  = ack;
        bus.data_i      = rdata;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_inst_req"},  bus.inst_req_o, 32'd0);
        checkOutput({tag, "_inst_addr"}, bus.inst_addr_o, 32'h0);
        checkOutput({tag, "_data_req"},  bus.data_req_o, 32'd0);
        checkOutput({tag, "_data_we"},   bus.data_we_o, 32'd0);
        checkOutput({tag, "_data_addr"}, bus.data_addr_o, 32'd0);
        checkOutput({tag, "_data_o"},    bus.data_o, 32'd0);
        checkOutput({tag, "_retire"},    bus.retire_o, 32'd0);
        checkOutput({tag, "_halt"},      bus.halt_o, 32'd0);
    endtask

    task automatic serveFetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
        int n = 0;
        while (bus.inst_req_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fetch_req", bus.inst_req_o, 32'd1);
        checkOutput("fetch_addr", bus.inst_addr_o, addr);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            checkOutput("fetch_hold_req", bus.inst_req_o, 32'd1);
            checkOutput("fetch_hold_addr", bus.inst_addr_o, addr);
        end
        bus.inst_i     = word;
        bus.inst_ack_i = 1'b1;
        @(negedge clk);
        bus.inst_ack_i = 1'b0;
        bus.inst_i     = 32'hDEAD_0000;
        checkOutput("fetch_drop", bus.inst_req_o, 32'd0);
    endtask

    task automatic serveData(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits);
        int n = 0;
        while (bus.data_req_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("data_req", bus.data_req_o, 32'd1);
        checkOutput("data_we", bus.data_we_o, {31'd0, we});
        checkOutput("data_addr", bus.data_addr_o, addr);
        checkOutput("mem_no_fetch", bus.inst_req_o, 32'd0);
        if (we) checkOutput("data_wdata", bus.data_o, wdata);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            checkOutput("data_hold_req", bus.data_req_o, 32'd1);
            checkOutput("data_hold_addr", bus.data_addr_o, addr);
        end
        applyStimulus(1'b0, 1'b1, rdata);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h1234_5678);
        checkOutput("data_drop", bus.data_req_o, 32'd0);
    endtask

    task automatic checkDelta(input string tag, input int idx, input int unsigned exp);
        int unsigned obs = 0;
        if (retire_cyc.size() > idx) obs = retire_cyc[idx] - retire_cyc[idx-1];
        checkOutput(tag, obs, exp);
    endtask

    initial begin
        int n;
        int seen_req;
        int retires_before;
        logic [31:0] lw_pc;

        bus.inst_ack_i = 1'b0;
        bus.inst_i     = 32'd0;
        applyStimulus(1'b1, 1'b0, 32'd0);

        repeat (3) begin
            @(negedge clk);
            checkResetOutputs("reset");
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("first_req", bus.inst_req_o, 32'd1);
        checkOutput("first_addr", bus.inst_addr_o, 32'h0);

        // ADDI x1,x0,5 ; ADD x2,x1,x1 ; SW x2,0x40(x0)
        serveFetch(32'h000, 32'h0050_0093, 0);
        serveFetch(32'h004, 32'h0010_8133, 0);
        serveFetch(32'h008, 32'h0420_2023, 0);
        serveData(1'b1, 32'h40, 32'd10, 32'd0, 0);

        // LW x3,0x80(x0) with 3 fetch and 2 data wait cycles
        serveFetch(32'h00C, 32'h0800_2183, 3);
        checkDelta("cpi_add", 1, 4);
        checkDelta("cpi_sw", 2, 5);
        checkOutput("store_count", data_txn, 32'd1);
        serveData(1'b0, 32'h80, 32'd0, 32'hDEAD_BEEF, 2);

        // SW x3,0x44(x0) exposes the loaded word
        serveFetch(32'h010, 32'h0430_2223, 0);
        checkDelta("cpi_lw_wait", 3, 10);
        serveData(1'b1, 32'h44, 32'hDEAD_BEEF, 32'd0, 0);

        // x4=-1, x5=1 ; BLT taken to 40 ; BGE not taken ; JAL x0 to 0x100 ; JAL x1,+16
        serveFetch(32'h014, 32'hFFF0_0213, 0);
        checkDelta("cpi_sw2", 4, 5);
        serveFetch(32'h018, 32'h0010_0293, 0);
        serveFetch(32'h01C, 32'h0052_4663, 0);
        serveFetch(32'h028, 32'h0052_5663, 0);
        serveFetch(32'h02C, 32'h0D40_006F, 0);
        serveFetch(32'h100, 32'h0100_00EF, 0);
        serveFetch(32'h110, 32'h0410_2423, 0);
        checkDelta("cpi_branch", 8, 4);
        serveData(1'b1, 32'h48, 32'h104, 32'd0, 0);

        // ADDI x0,x0,7 ; SW x0,0x4C(x0)
        serveFetch(32'h114, 32'h0070_0013, 0);
        serveFetch(32'h118, 32'h0400_2623, 0);
        serveData(1'b1, 32'h4C, 32'd0, 32'd0, 0);

        serveFetch(32'h11C, 32'hFFFF_FFFF, 0);
        checkOutput("retire_count", retire_cyc.size(), 32'd14);

`ifdef RV_ILLEGAL_TRAP_EN
        @(negedge clk);
        checkOutput("halt_set", bus.halt_o, 32'd1);
        seen_req = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.inst_req_o !== 1'b0 || bus.data_req_o !== 1'b0) seen_req++;
        end
        checkOutput("halt_no_req", seen_req, 32'd0);
        checkOutput("halt_held", bus.halt_o, 32'd1);
        checkOutput("halt_pc", bus.inst_addr_o, 32'h11C);
        checkOutput("halt_no_retire", retire_cyc.size(), 32'd14);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("halt_cleared", bus.halt_o, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        lw_pc = 32'h000;
`else
        seen_req = 0;
        lw_pc = 32'h120;
        checkOutput("nop_halt_low", bus.halt_o, 32'd0);
`endif

        // LW x6,0x80(x0), then reset during its data wait (ack lands in the reset cycle)
        serveFetch(lw_pc, 32'h0800_2303, 0);
`ifndef RV_ILLEGAL_TRAP_EN
        checkDelta("cpi_illegal_nop", 14, 4);
`endif
        n = 0;
        while (bus.data_req_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_data_req", bus.data_req_o, 32'd1);
        checkOutput("mid_data_addr", bus.data_addr_o, 32'h80);
        @(negedge clk);
        retires_before = retire_cyc.size();
        applyStimulus(1'b1, 1'b1, 32'hBAD0_BAD0);
        @(negedge clk);
        checkResetOutputs("mid_reset");
        applyStimulus(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("restart_req", bus.inst_req_o, 32'd1);
        checkOutput("restart_addr", bus.inst_addr_o, 32'h0);
        checkOutput("mid_no_retire", retire_cyc.size(), retires_before);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
